// File: rtl/hvsync_decoder.sv
// Recovers beam position, line/frame lengths and a timing-lock flag from incoming hsync/vsync.
// Define HVSYNC_DECODER_ERRCNT_EN to add the lock_loss_count output.
module hvsync_decoder #(
    parameter int H_DISPLAY  = 320,
    parameter int V_DISPLAY  = 240,
    parameter int LOCK_LINES = 4,
    parameter int MISS_LIMIT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hsync,
    input  logic       vsync,
    output logic [8:0] hpos,
    output logic [8:0] vpos,
    output logic [8:0] line_max,
    output logic [8:0] frame_max,
    output logic       locked,
    output logic       frame_start,
    output logic       display_on
`ifdef HVSYNC_DECODER_ERRCNT_EN
    ,
    output logic [7:0] lock_loss_count
`endif
);

    localparam logic [8:0] H_DISP  = 9'(H_DISPLAY);
    localparam logic [8:0] V_DISP  = 9'(V_DISPLAY);
    localparam logic [7:0] LOCK_N  = 8'(LOCK_LINES);
    localparam logic [7:0] MISS_N  = 8'(MISS_LIMIT);
    localparam logic [8:0] POS_MAX = 9'd511;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       hs_q;
    logic       vs_q;
    logic       hrise;
    logic       vrise;
    logic       timeout;
    logic [7:0] match_cnt;
    logic [7:0] match_nxt;
    logic [7:0] miss_cnt;
    logic [7:0] miss_nxt;
    logic [8:0] line_max_nxt;
    logic       frame_seen;
    logic       frame_seen_nxt;

    assign hrise = hsync & ~hs_q;
    assign vrise = vsync & ~vs_q;

    // Fires on the edge where hpos would land on 511, so locked drops as hpos saturates.
    assign timeout = (state != SEARCH) && !hrise && (hpos >= (POS_MAX - 9'd1));

    assign display_on = locked & frame_seen & (hpos < H_DISP) & (vpos < V_DISP);

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            hpos        <= 9'd0;
            vpos        <= 9'd0;
            frame_max   <= 9'd0;
            frame_start <= 1'b0;
        end else begin
            hs_q        <= hsync;
            vs_q        <= vsync;
            frame_start <= vrise;

            if (hrise)
                hpos <= 9'd0;
            else if (hpos != POS_MAX)
                hpos <= hpos + 9'd1;

            // vsync takes priority over a coincident hsync rise
            if (vrise) begin
                vpos      <= 9'd0;
                frame_max <= vpos;
            end else if (hrise && (vpos != POS_MAX)) begin
                vpos <= vpos + 9'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SEARCH;
            match_cnt  <= 8'd0;
            miss_cnt   <= 8'd0;
            line_max   <= 9'd0;
            frame_seen <= 1'b0;
            locked     <= 1'b0;
        end else begin
            state      <= state_nxt;
            match_cnt  <= match_nxt;
            miss_cnt   <= miss_nxt;
            line_max   <= line_max_nxt;
            frame_seen <= frame_seen_nxt;
            locked     <= (state_nxt == LOCKED);
        end
    end

    // hpos at the hsync rise is the measured line period minus one.
    always_comb begin
        state_nxt      = state;
        match_nxt      = match_cnt;
        miss_nxt       = miss_cnt;
        line_max_nxt   = line_max;
        frame_seen_nxt = frame_seen;

        if (vrise && (state == LOCKED))
            frame_seen_nxt = 1'b1;

        case (state)
            SEARCH: begin
                if (hrise) begin
                    state_nxt    = ACQUIRE;
                    match_nxt    = 8'd0;
                    line_max_nxt = 9'd0;
                end
            end
            ACQUIRE: begin
                if (timeout) begin
                    state_nxt      = SEARCH;
                    match_nxt      = 8'd0;
                    frame_seen_nxt = 1'b0;
                end else if (hrise) begin
                    line_max_nxt = hpos;
                    if (hpos == line_max) begin
                        match_nxt = match_cnt + 8'd1;
                        if ((match_cnt + 8'd1) == LOCK_N) begin
                            state_nxt = LOCKED;
                            miss_nxt  = 8'd0;
                        end
                    end else begin
                        match_nxt = 8'd0;
                    end
                end
            end
            LOCKED: begin
                if (timeout) begin
                    state_nxt      = SEARCH;
                    miss_nxt       = 8'd0;
                    frame_seen_nxt = 1'b0;
                end else if (hrise) begin
                    if (hpos == line_max) begin
                        miss_nxt = 8'd0;
                    end else if ((miss_cnt + 8'd1) == MISS_N) begin
                        state_nxt      = SEARCH;
                        miss_nxt       = 8'd0;
                        frame_seen_nxt = 1'b0;
                    end else begin
                        miss_nxt = miss_cnt + 8'd1;
                    end
                end
            end
            default: begin
                state_nxt      = SEARCH;
                frame_seen_nxt = 1'b0;
            end
        endcase
    end

`ifdef HVSYNC_DECODER_ERRCNT_EN
    // Both event kinds may land on one edge, so they are summed before saturating.
    logic       lock_lost;
    logic       frame_changed;
    logic [8:0] prev_frame;
    logic [8:0] loss_sum;

    assign lock_lost     = (state == LOCKED) && (state_nxt == SEARCH);
    assign frame_changed = vrise && locked && (prev_frame != 9'd0) && (vpos != prev_frame);
    assign loss_sum      = {1'b0, lock_loss_count} + {8'd0, lock_lost} + {8'd0, frame_changed};

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_loss_count <= 8'd0;
            prev_frame      <= 9'd0;
        end else begin
            if (vrise && (vpos != 9'd0))
                prev_frame <= vpos;
            lock_loss_count <= (loss_sum > 9'd255) ? 8'd255 : loss_sum[7:0];
        end
    end
`endif

endmodule

// File: tb/tb_hvsync_decoder.sv
// Self-checking bench for hvsync_decoder: lock acquisition, frame recovery, miss/timeout loss, reset.
module tb_hvsync_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       hsync;
    logic       vsync;
    logic [8:0] hpos;
    logic [8:0] vpos;
    logic [8:0] line_max;
    logic [8:0] frame_max;
    logic       locked;
    logic       frame_start;
    logic       display_on;
`ifdef HVSYNC_DECODER_ERRCNT_EN
    logic [7:0] lock_loss_count;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         id;
        logic [8:0] hp;
        logic       lk;
        logic [8:0] lmax;
    } exp_t;

    exp_t sb[$];

    hvsync_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .hsync       (hsync),
        .vsync       (vsync),
        .hpos        (hpos),
        .vpos        (vpos),
        .line_max    (line_max),
        .frame_max   (frame_max),
        .locked      (locked),
        .frame_start (frame_start),
        .display_on  (display_on)
`ifdef HVSYNC_DECODER_ERRCNT_EN
        ,
        .lock_loss_count (lock_loss_count)
`endif
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            tick();
    endtask

    task automatic hs_edge(input logic vs);
        hsync = 1'b1;
        vsync = vs;
        tick();
        hsync = 1'b0;
        vsync = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        hsync = 1'b0;
        vsync = 1'b0;
        tick();
        tick();
        checks++;
        if (hpos !== 9'd0 || vpos !== 9'd0) begin
            errors++;
            $display("[TB] FAIL reset_pos: got hpos=%0d vpos=%0d expected 0 0", hpos, vpos);
        end
        checks++;
        if (line_max !== 9'd0 || frame_max !== 9'd0) begin
            errors++;
            $display("[TB] FAIL reset_max: got line_max=%0d frame_max=%0d expected 0 0", line_max, frame_max);
        end
        checks++;
        if (locked !== 1'b0 || frame_start !== 1'b0 || display_on !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got locked=%b frame_start=%b display_on=%b expected 0 0 0",
                     locked, frame_start, display_on);
        end
`ifdef HVSYNC_DECODER_ERRCNT_EN
        checks++;
        if (lock_loss_count !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_losscnt: got %0d expected 0", lock_loss_count);
        end
`endif
    endtask

    task automatic test_lock();
        exp_t e;
        reset = 1'b0;
        idle(3);
        for (int i = 1; i <= 6; i++) begin
            e.id   = i;
            e.hp   = 9'd0;
            e.lk   = (i >= 6);
            e.lmax = (i == 1) ? 9'd0 : 9'd320;
            sb.push_back(e);
            hs_edge(1'b0);
            e = sb.pop_front();
            checks++;
            if (hpos !== e.hp) begin
                errors++;
                $display("[TB] FAIL lock_hpos rise %0d: got %0d expected %0d", e.id, hpos, e.hp);
            end
            checks++;
            if (locked !== e.lk) begin
                errors++;
                $display("[TB] FAIL lock_locked rise %0d: got %b expected %b", e.id, locked, e.lk);
            end
            checks++;
            if (line_max !== e.lmax) begin
                errors++;
                $display("[TB] FAIL lock_line_max rise %0d: got %0d expected %0d", e.id, line_max, e.lmax);
            end
            idle(320);
        end
    endtask

    task automatic test_frame();
        logic exp_d;
        hs_edge(1'b1);
        checks++;
        if (frame_start !== 1'b1 || vpos !== 9'd0 || hpos !== 9'd0) begin
            errors++;
            $display("[TB] FAIL frame_first: got frame_start=%b vpos=%0d hpos=%0d expected 1 0 0",
                     frame_start, vpos, hpos);
        end
        checks++;
        if (frame_max !== 9'd6) begin
            errors++;
            $display("[TB] FAIL frame_max_first: got %0d expected 6", frame_max);
        end
        checks++;
        if (display_on !== 1'b1) begin
            errors++;
            $display("[TB] FAIL frame_disp_origin: got %b expected 1", display_on);
        end
        tick();
        checks++;
        if (frame_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL frame_start_width: got %b expected 0", frame_start);
        end
        idle(318);
        checks++;
        if (display_on !== 1'b1) begin
            errors++;
            $display("[TB] FAIL frame_disp_h319: got %b expected 1", display_on);
        end
        tick();
        checks++;
        if (display_on !== 1'b0) begin
            errors++;
            $display("[TB] FAIL frame_disp_h320: got %b expected 0", display_on);
        end
        for (int k = 1; k <= 240; k++) begin
            exp_d = (k < 240);
            hs_edge(1'b0);
            checks++;
            if (vpos !== 9'(k) || display_on !== exp_d) begin
                errors++;
                $display("[TB] FAIL frame_line%0d_start: got vpos=%0d disp=%b expected %0d %b",
                         k, vpos, display_on, k, exp_d);
            end
            idle(319);
            checks++;
            if (display_on !== exp_d) begin
                errors++;
                $display("[TB] FAIL frame_line%0d_h319: got %b expected %b", k, display_on, exp_d);
            end
            tick();
            checks++;
            if (display_on !== 1'b0) begin
                errors++;
                $display("[TB] FAIL frame_line%0d_h320: got %b expected 0", k, display_on);
            end
        end
        hs_edge(1'b1);
        checks++;
        if (frame_max !== 9'd240 || vpos !== 9'd0 || frame_start !== 1'b1) begin
            errors++;
            $display("[TB] FAIL frame_second: got frame_max=%0d vpos=%0d frame_start=%b expected 240 0 1",
                     frame_max, vpos, frame_start);
        end
    endtask

    task automatic test_line_miss();
        int   lens[4]   = '{300, 321, 300, 300};
        logic exp_lk[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.id   = i;
            e.hp   = 9'd0;
            e.lk   = exp_lk[i];
            e.lmax = 9'd320;
            sb.push_back(e);
            idle(lens[i] - 1);
            hs_edge(1'b0);
            e = sb.pop_front();
            checks++;
            if (locked !== e.lk) begin
                errors++;
                $display("[TB] FAIL miss_locked line %0d: got %b expected %b", e.id, locked, e.lk);
            end
            checks++;
            if (line_max !== e.lmax) begin
                errors++;
                $display("[TB] FAIL miss_line_max line %0d: got %0d expected %0d", e.id, line_max, e.lmax);
            end
        end
        checks++;
        if (display_on !== 1'b0) begin
            errors++;
            $display("[TB] FAIL miss_display: got %b expected 0", display_on);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        bit   seen510 = 1'b0;
        bit   found   = 1'b0;
        idle(320);
        for (int i = 1; i <= 6; i++) begin
            hs_edge(1'b0);
            idle(320);
        end
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_prelock: got %b expected 1", locked);
        end
        for (int c = 0; c < 600; c++) begin
            tick();
            if (hpos == 9'd510 && !seen510) begin
                seen510 = 1'b1;
                checks++;
                if (locked !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL timeout_h510_locked: got %b expected 1", locked);
                end
            end
            if (hpos == 9'd511 && !found) begin
                found = 1'b1;
                checks++;
                if (locked !== 1'b0 || display_on !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL timeout_h511: got locked=%b disp=%b expected 0 0", locked, display_on);
                end
            end
        end
        checks++;
        if (!found || hpos !== 9'd511) begin
            errors++;
            $display("[TB] FAIL timeout_saturate: got hpos=%0d reached=%b expected 511 1", hpos, found);
        end
        for (int i = 1; i <= 6; i++) begin
            e.id   = i;
            e.hp   = 9'd0;
            e.lk   = (i == 6);
            e.lmax = (i == 1) ? 9'd0 : 9'd320;
            sb.push_back(e);
            hs_edge(1'b0);
            e = sb.pop_front();
            checks++;
            if (hpos !== e.hp || locked !== e.lk || line_max !== e.lmax) begin
                errors++;
                $display("[TB] FAIL relock rise %0d: got hpos=%0d locked=%b line_max=%0d expected %0d %b %0d",
                         e.id, hpos, locked, line_max, e.hp, e.lk, e.lmax);
            end
            idle(320);
        end
    endtask

    task automatic test_coincident();
        checks++;
        if (vpos !== 9'd16) begin
            errors++;
            $display("[TB] FAIL coinc_pre_vpos: got %0d expected 16", vpos);
        end
        hs_edge(1'b1);
        checks++;
        if (vpos !== 9'd0 || hpos !== 9'd0 || frame_start !== 1'b1) begin
            errors++;
            $display("[TB] FAIL coinc_edge: got vpos=%0d hpos=%0d frame_start=%b expected 0 0 1",
                     vpos, hpos, frame_start);
        end
        checks++;
        if (frame_max !== 9'd16) begin
            errors++;
            $display("[TB] FAIL coinc_frame_max: got %0d expected 16", frame_max);
        end
    endtask

    task automatic test_reset_high_sync();
        hsync = 1'b1;
        vsync = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({hpos, vpos, line_max, frame_max} !== 36'd0 || locked !== 1'b0 || frame_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset: got hpos=%0d vpos=%0d line_max=%0d frame_max=%0d locked=%b fs=%b expected all 0",
                     hpos, vpos, line_max, frame_max, locked, frame_start);
        end
        reset = 1'b0;
        idle(5);
        checks++;
        if (hpos !== 9'd5 || vpos !== 9'd0 || frame_start !== 1'b0 || locked !== 1'b0) begin
            errors++;
            $display("[TB] FAIL held_high_no_edge: got hpos=%0d vpos=%0d fs=%b locked=%b expected 5 0 0 0",
                     hpos, vpos, frame_start, locked);
        end
        hsync = 1'b0;
        vsync = 1'b0;
        tick();
        hs_edge(1'b0);
        checks++;
        if (hpos !== 9'd0 || line_max !== 9'd0) begin
            errors++;
            $display("[TB] FAIL first_rise_after_release: got hpos=%0d line_max=%0d expected 0 0", hpos, line_max);
        end
`ifdef HVSYNC_DECODER_ERRCNT_EN
        for (int i = 2; i <= 6; i++) begin
            idle(320);
            hs_edge(1'b0);
        end
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("[TB] FAIL errcnt_lock: got %b expected 1", locked);
        end
        idle(299);
        hs_edge(1'b0);
        idle(299);
        hs_edge(1'b0);
        checks++;
        if (locked !== 1'b0 || lock_loss_count !== 8'd1) begin
            errors++;
            $display("[TB] FAIL errcnt_loss: got locked=%b count=%0d expected 0 1", locked, lock_loss_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_lock();
        test_frame();
        test_line_miss();
        test_timeout();
        test_coincident();
        test_reset_high_sync();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Every stimulus loop is bounded; this only guards against a stuck simulation.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
